// File: rtl/vdp_reg_arb_pkg.sv
// Shared types for the VDP register-write arbiter: widths, requester id and write entry.
`timescale 1ns/1ps
package vdp_reg_arb_pkg;

  localparam int REG_ADDR_W = 6;
  localparam int REG_DATA_W = 16;
  localparam int WAIT_W     = 4;

  typedef enum logic {
    REQ_HOST   = 1'b0,
    REQ_COPPER = 1'b1
  } req_t;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] address;
    logic [REG_DATA_W-1:0] data;
  } write_entry_t;

  // Starvation counter step: saturates at the configured ceiling.
  function automatic logic [WAIT_W-1:0] wait_step(input logic [WAIT_W-1:0] cur,
                                                  input logic [WAIT_W-1:0] ceiling);
    if (cur < ceiling) begin
      return cur + 1'b1;
    end
    return cur;
  endfunction

endpackage

// File: rtl/vdp_reg_write_fifo.sv
// Host write buffer: power-of-two depth, extra pointer MSB distinguishes full from empty.
`timescale 1ns/1ps
module vdp_reg_write_fifo
  import vdp_reg_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  write_entry_t push_entry,
  input  logic         pop,
  output write_entry_t head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_MSB = {1'b1, {AW{1'b0}}};

  write_entry_t mem [DEPTH];
  logic [AW:0]  wr_ptr_reg;
  logic [AW:0]  rd_ptr_reg;
  logic         push_ok;
  logic         pop_ok;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = ((wr_ptr_reg ^ rd_ptr_reg) == PTR_MSB);
  // A full FIFO refuses a push even when a pop happens on the same edge.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg[AW-1:0]] <= push_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/vdp_reg_write_arbiter.sv
// Arbitrates the VDP register-file write port between host (FIFO) and copper (holding register).
// Optional macro VDP_REG_ARB_STALL_COUNT_EN builds the copper stall counter.
`timescale 1ns/1ps
module vdp_reg_write_arbiter
  import vdp_reg_arb_pkg::*;
#(
  parameter int HOST_FIFO_DEPTH = 2,
  parameter int HOST_MAX_WAIT   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] host_write_address,
  input  logic [REG_DATA_W-1:0] host_write_data,
  input  logic                  host_write_en,
  output logic                  host_ready,
  input  logic [REG_ADDR_W-1:0] copper_write_address,
  input  logic [REG_DATA_W-1:0] copper_write_data,
  input  logic                  copper_write_en,
  output logic                  copper_ready,
  output logic [REG_ADDR_W-1:0] reg_write_address,
  output logic [REG_DATA_W-1:0] reg_write_data,
  output logic                  reg_write_en,
  input  logic                  reg_write_ready,
  output logic                  reg_write_source,
  output logic [15:0]           copper_stall_count
);

  localparam logic [WAIT_W-1:0] MAX_WAIT = WAIT_W'(HOST_MAX_WAIT);

  write_entry_t      host_entry;
  write_entry_t      fifo_head;
  write_entry_t      hold_entry_reg;
  write_entry_t      out_entry_reg;
  write_entry_t      grant_entry;
  req_t              source_reg;
  req_t              grant_source;
  logic              hold_valid_reg;
  logic              out_valid_reg;
  logic [WAIT_W-1:0] host_wait_reg;
  logic [WAIT_W-1:0] host_wait_next;
  logic              fifo_full;
  logic              fifo_empty;
  logic              host_push;
  logic              host_pop;
  logic              copper_accept;
  logic              host_pending;
  logic              copper_pending;
  logic              out_free;
  logic              out_load;
  logic              grant_host;

  // Request stage.
  assign host_ready    = !fifo_full;
  assign copper_ready  = !hold_valid_reg;
  assign host_push     = host_write_en && host_ready;
  assign copper_accept = copper_write_en && copper_ready;
  assign host_entry    = '{address: host_write_address, data: host_write_data};

  vdp_reg_write_fifo #(
    .DEPTH (HOST_FIFO_DEPTH)
  ) u_host_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (host_push),
    .push_entry (host_entry),
    .pop        (host_pop),
    .head       (fifo_head),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  // Grant: copper wins unless the host has waited out its allowance.
  assign host_pending   = !fifo_empty;
  assign copper_pending = hold_valid_reg;
  assign out_free       = !out_valid_reg || reg_write_ready;
  assign out_load       = out_free && (host_pending || copper_pending);
  assign grant_host     = host_pending && (!copper_pending || (host_wait_reg == MAX_WAIT));
  assign host_pop       = out_load && grant_host;

  always_comb begin
    grant_entry  = hold_entry_reg;
    grant_source = REQ_COPPER;
    if (grant_host) begin
      grant_entry  = fifo_head;
      grant_source = REQ_HOST;
    end
  end

  always_comb begin
    host_wait_next = host_wait_reg;
    if (fifo_empty || host_pop) begin
      host_wait_next = '0;
    end else if (out_load) begin
      host_wait_next = wait_step(host_wait_reg, MAX_WAIT);
    end
  end

  // The holding register is never freed and reloaded on one edge: accept needs it empty,
  // a copper grant needs it full.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_valid_reg <= 1'b0;
      hold_entry_reg <= '0;
    end else if (copper_accept) begin
      hold_valid_reg <= 1'b1;
      hold_entry_reg <= '{address: copper_write_address, data: copper_write_data};
    end else if (out_load && !grant_host) begin
      hold_valid_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_reg <= 1'b0;
      out_entry_reg <= '0;
      source_reg    <= REQ_HOST;
      host_wait_reg <= '0;
    end else begin
      host_wait_reg <= host_wait_next;
      if (out_load) begin
        out_valid_reg <= 1'b1;
        out_entry_reg <= grant_entry;
        source_reg    <= grant_source;
      end else if (reg_write_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign reg_write_en      = out_valid_reg;
  assign reg_write_address = out_entry_reg.address;
  assign reg_write_data    = out_entry_reg.data;
  assign reg_write_source  = source_reg;

`ifdef VDP_REG_ARB_STALL_COUNT_EN
  logic [15:0] stall_count_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count_reg <= '0;
    end else if (copper_write_en && !copper_ready && (stall_count_reg != 16'hFFFF)) begin
      stall_count_reg <= stall_count_reg + 16'd1;
    end
  end

  assign copper_stall_count = stall_count_reg;
`else
  assign copper_stall_count = 16'h0000;
`endif

endmodule

// File: tb/tb_vdp_reg_write_arbiter.sv
// Directed scoreboard bench for vdp_reg_write_arbiter; a negedge monitor checks every issued write.
`timescale 1ns/1ps
module tb_vdp_reg_write_arbiter;
  import vdp_reg_arb_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  host_write_address;
  logic [15:0] host_write_data;
  logic        host_write_en;
  logic        host_ready;
  logic [5:0]  copper_write_address;
  logic [15:0] copper_write_data;
  logic        copper_write_en;
  logic        copper_ready;
  logic [5:0]  reg_write_address;
  logic [15:0] reg_write_data;
  logic        reg_write_en;
  logic        reg_write_ready;
  logic        reg_write_source;
  logic [15:0] copper_stall_count;

  typedef struct packed {
    logic [5:0]  address;
    logic [15:0] data;
    logic        source;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  vdp_reg_write_arbiter #(
    .HOST_FIFO_DEPTH (2),
    .HOST_MAX_WAIT   (4)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .host_write_address   (host_write_address),
    .host_write_data      (host_write_data),
    .host_write_en        (host_write_en),
    .host_ready           (host_ready),
    .copper_write_address (copper_write_address),
    .copper_write_data    (copper_write_data),
    .copper_write_en      (copper_write_en),
    .copper_ready         (copper_ready),
    .reg_write_address    (reg_write_address),
    .reg_write_data       (reg_write_data),
    .reg_write_en         (reg_write_en),
    .reg_write_ready      (reg_write_ready),
    .reg_write_source     (reg_write_source),
    .copper_stall_count   (copper_stall_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end else begin
      $display("check %s: 0x%0h ok", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_write(input logic [5:0] a, input logic [15:0] d, input logic s);
    exp_q.push_back('{address: a, data: d, source: s});
  endtask

  task automatic host_drive(input logic [5:0] a, input logic [15:0] d);
    host_write_en      = 1'b1;
    host_write_address = a;
    host_write_data    = d;
  endtask

  task automatic copper_drive(input logic [5:0] a, input logic [15:0] d);
    copper_write_en      = 1'b1;
    copper_write_address = a;
    copper_write_data    = d;
  endtask

  // Monitor: a write transfers on the posedge following a negedge where en && ready.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && reg_write_en && reg_write_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got addr=0x%0h data=0x%0h src=%0d, expected none",
                   reg_write_address, reg_write_data, reg_write_source);
        end else begin
          e = exp_q.pop_front();
          if (reg_write_address !== e.address || reg_write_data !== e.data ||
              reg_write_source !== e.source) begin
            errors++;
            $display("FAIL write_order: got addr=0x%0h data=0x%0h src=%0d, expected addr=0x%0h data=0x%0h src=%0d",
                     reg_write_address, reg_write_data, reg_write_source,
                     e.address, e.data, e.source);
          end else begin
            $display("write addr=0x%0h data=0x%0h src=%0d ok", e.address, e.data, e.source);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    int hi_cycles;
    logic [15:0] stall_exp;

    reset = 1'b1;
    host_write_en = 1'b0; host_write_address = '0; host_write_data = '0;
    copper_write_en = 1'b0; copper_write_address = '0; copper_write_data = '0;
    reg_write_ready = 1'b0;
    repeat (3) tick();
    reset = 1'b0;

    check("rst_en", 32'(reg_write_en), 32'd0);
    check("rst_addr", 32'(reg_write_address), 32'd0);
    check("rst_data", 32'(reg_write_data), 32'd0);
    check("rst_src", 32'(reg_write_source), 32'd0);
    check("rst_host_ready", 32'(host_ready), 32'd1);
    check("rst_copper_ready", 32'(copper_ready), 32'd1);
    check("rst_stall", 32'(copper_stall_count), 32'd0);

    // Host-only stream, one cycle latency, back-to-back output.
    reg_write_ready = 1'b1;
    expect_write(6'h05, 16'h1234, 1'b0);
    expect_write(6'h06, 16'hABCD, 1'b0);
    host_drive(6'h05, 16'h1234);
    tick();
    check("host_latency_en", 32'(reg_write_en), 32'd0);
    host_drive(6'h06, 16'hABCD);
    tick();
    host_write_en = 1'b0;
    check("host_first_en", 32'(reg_write_en), 32'd1);
    check("host_first_addr", 32'(reg_write_address), 32'h05);
    tick();
    check("host_second_en", 32'(reg_write_en), 32'd1);
    check("host_second_addr", 32'(reg_write_address), 32'h06);
    tick();
    check("host_idle_en", 32'(reg_write_en), 32'd0);

    // Collision: copper first, host next cycle.
    expect_write(6'h02, 16'h2222, 1'b1);
    expect_write(6'h01, 16'h1111, 1'b0);
    host_drive(6'h01, 16'h1111);
    copper_drive(6'h02, 16'h2222);
    tick();
    host_write_en = 1'b0; copper_write_en = 1'b0;
    tick();
    check("collide_first_src", 32'(reg_write_source), 32'd1);
    tick();
    check("collide_second_src", 32'(reg_write_source), 32'd0);
    tick();
    check("collide_idle_en", 32'(reg_write_en), 32'd0);

    // Starvation: output accepts every other edge so the copper refills and keeps winning.
    for (int i = 0; i < 4; i++) expect_write(6'(8'h10 + i), 16'(16'hC000 + i), 1'b1);
    expect_write(6'h20, 16'h5A5A, 1'b0);
    expect_write(6'h14, 16'hC004, 1'b1);
    reg_write_ready = 1'b0;
    host_drive(6'h20, 16'h5A5A);
    copper_drive(6'h10, 16'hC000);
    tick();
    host_write_en = 1'b0; copper_write_en = 1'b0;
    sent = 1;
    for (int k = 1; k <= 14; k++) begin
      if (k == 8) check("host_wait_at_max", 32'(dut.host_wait_reg), 32'd4);
      if (k == 10) check("host_wait_cleared", 32'(dut.host_wait_reg), 32'd0);
      reg_write_ready = k[0];
      if (copper_ready && sent < 5) begin
        copper_drive(6'(8'h10 + sent), 16'(16'hC000 + sent));
        sent++;
      end else begin
        copper_write_en = 1'b0;
      end
      tick();
    end
    copper_write_en = 1'b0;
    reg_write_ready = 1'b1;
    tick();
    check("starve_wait_zero", 32'(dut.host_wait_reg), 32'd0);
    check("starve_idle_en", 32'(reg_write_en), 32'd0);

    // Backpressure: output held, FIFO full, holding register occupied.
    expect_write(6'h30, 16'h3001, 1'b1);
    expect_write(6'h31, 16'h3002, 1'b1);
    expect_write(6'h38, 16'h3801, 1'b0);
    expect_write(6'h39, 16'h3802, 1'b0);
    reg_write_ready = 1'b0;
    host_drive(6'h38, 16'h3801);
    copper_drive(6'h30, 16'h3001);
    tick();
    copper_write_en = 1'b0;
    host_drive(6'h39, 16'h3802);
    tick();
    host_write_en = 1'b0;
    copper_drive(6'h31, 16'h3002);
    tick();
    check("bp_host_ready", 32'(host_ready), 32'd0);
    check("bp_copper_ready", 32'(copper_ready), 32'd0);
    host_drive(6'h3F, 16'hDEAD);
    copper_drive(6'h3E, 16'hBEEF);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_en", 32'(reg_write_en), 32'd1);
      check("bp_hold_word", {10'd0, reg_write_address, reg_write_data}, {10'd0, 6'h30, 16'h3001});
    end
    host_write_en = 1'b0; copper_write_en = 1'b0;
    reg_write_ready = 1'b1;
    repeat (5) tick();
    check("bp_drained_en", 32'(reg_write_en), 32'd0);

    // Reset mid-stream with FIFO full, output valid, and writes presented on the reset edge.
    reg_write_ready = 1'b0;
    host_drive(6'h0A, 16'h0A0A);
    copper_drive(6'h0B, 16'h0B0B);
    tick();
    copper_write_en = 1'b0;
    host_drive(6'h0C, 16'h0C0C);
    tick();
    check("pre_reset_full", 32'(host_ready), 32'd0);
    check("pre_reset_valid", 32'(reg_write_en), 32'd1);
    reset = 1'b1;
    host_drive(6'h0D, 16'h0D0D);
    copper_drive(6'h0E, 16'h0E0E);
    tick();
    reset = 1'b0;
    host_write_en = 1'b0; copper_write_en = 1'b0;
    check("mid_reset_en", 32'(reg_write_en), 32'd0);
    check("mid_reset_host_ready", 32'(host_ready), 32'd1);
    check("mid_reset_copper_ready", 32'(copper_ready), 32'd1);
    check("mid_reset_stall", 32'(copper_stall_count), 32'd0);
    reg_write_ready = 1'b1;
    hi_cycles = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (reg_write_en) hi_cycles++;
    end
    check("no_stale_write", 32'(hi_cycles), 32'd0);

    // Copper held off for 7 cycles behind a stalled output.
    expect_write(6'h21, 16'h7001, 1'b1);
    expect_write(6'h22, 16'h7002, 1'b1);
    reg_write_ready = 1'b0;
    copper_drive(6'h21, 16'h7001);
    tick();
    copper_write_en = 1'b0;
    tick();
    copper_drive(6'h22, 16'h7002);
    tick();
    copper_drive(6'h23, 16'h7003);
    repeat (7) tick();
    copper_write_en = 1'b0;
`ifdef VDP_REG_ARB_STALL_COUNT_EN
    stall_exp = 16'd7;
`else
    stall_exp = 16'd0;
`endif
    check("stall_count", 32'(copper_stall_count), 32'(stall_exp));
    reg_write_ready = 1'b1;
    repeat (4) tick();
    check("stall_drained_en", 32'(reg_write_en), 32'd0);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
